// File: rtl/fwrisc_gpr_sb.sv
// ---------------------------------------------------------------------------
// fwrisc_gpr_sb
//
// General-purpose register file for the fwrisc core with a pending-write
// scoreboard. Decode reads operands and issues multi-cycle ops (loads,
// mul/div) through this block; writeback writes results back through it.
//
// After reset an optional sweep writes zero into every GPR, one register per
// cycle. The core must hold off while init_busy is high.
//
// Parameters
//   XLEN        data width of each register
//   RV32E       1: x1..x15 implemented, 0: x1..x31 (x0 is always zero)
//   N_RD_PORTS  number of independent read ports (1..3)
//   BYPASS      1: a write forwards to a same-cycle read of the same register
//   ZERO_INIT   1: clear all GPRs with a post-reset sweep
//
// Ports
//   clock, reset   clock and synchronous active-high reset
//   init_busy      high while the post-reset sweep is pending or running
//   rd_raddr       read addresses, port i at [5i+4:5i]
//   rd_rdata       registered read data, port i at [XLEN*i +: XLEN]
//   rd_pending     registered scoreboard bit of each port's read register
//   wr_en/addr/data  writeback port
//   issue_en/addr  marks a register as having a write outstanding
//   sb_any         OR of all scoreboard bits
//   addr_err       one-cycle pulse: RV32E access to an address with bit 4 set
// ---------------------------------------------------------------------------
module fwrisc_gpr_sb #(
    parameter int XLEN       = 32,
    parameter int RV32E      = 0,
    parameter int N_RD_PORTS = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_INIT  = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       init_busy,
    input  logic [5*N_RD_PORTS-1:0]    rd_raddr,
    output logic [XLEN*N_RD_PORTS-1:0] rd_rdata,
    output logic [N_RD_PORTS-1:0]      rd_pending,
    input  logic                       wr_en,
    input  logic [4:0]                 wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic                       issue_en,
    input  logic [4:0]                 issue_addr,
    output logic                       sb_any,
    output logic                       addr_err
);

    localparam int N_REGS = (RV32E != 0) ? 15 : 31;
    // Index width into the storage array: 16 or 32 entries (entry 0 unused).
    localparam int IDX_W  = (RV32E != 0) ? 4 : 5;
    localparam logic [4:0] LAST_PTR = 5'(N_REGS);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] ptr_q, ptr_d;

    // An address is backed by storage when it is not x0 and, for RV32E,
    // does not reach into the unimplemented upper half.
    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && !((RV32E != 0) && a[4]);
    endfunction

    // -----------------------------------------------------------------------
    // Sweep / run control
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= 5'd1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d   = 5'd1;
                state_d = (ZERO_INIT != 0) ? ST_CLEAR : ST_RUN;
            end
            ST_CLEAR: begin
                // The last register is cleared on the same edge that
                // enters RUN, so the sweep takes exactly N_REGS cycles.
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    logic run;
    logic clearing;

    assign run       = (state_q == ST_RUN);
    assign clearing  = (state_q == ST_CLEAR);
    assign init_busy = clearing || ((state_q == ST_INIT) && (ZERO_INIT != 0));

    // -----------------------------------------------------------------------
    // Storage: one shared write port used by the sweep and by writeback
    // -----------------------------------------------------------------------
    logic             wr_ok;
    logic             iss_ok;
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [XLEN-1:0]  ram_wdata;

    // Writeback and issue only act in RUN; both are ignored during the sweep.
    assign wr_ok  = run && wr_en && addr_ok(wr_addr);
    assign iss_ok = run && issue_en && addr_ok(issue_addr);

    assign ram_we    = clearing || wr_ok;
    assign ram_waddr = clearing ? ptr_q[IDX_W-1:0] : wr_addr[IDX_W-1:0];
    assign ram_wdata = clearing ? '0 : wr_data;

    logic [XLEN-1:0] regs_q [0:N_REGS];

    always_ff @(posedge clock) begin
        if (ram_we) begin
            regs_q[ram_waddr] <= ram_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Pending-write scoreboard
    // -----------------------------------------------------------------------
    logic [N_REGS:0] sb_q, sb_d;

    always_comb begin
        sb_d = sb_q;
        if (wr_ok) begin
            sb_d[wr_addr[IDX_W-1:0]] = 1'b0;
        end
        // Applied after the clear so a same-cycle issue of the register
        // being written leaves it pending.
        if (iss_ok) begin
            sb_d[issue_addr[IDX_W-1:0]] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign sb_any = |sb_q;

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    logic [N_RD_PORTS-1:0] rd_hi;

    generate
        for (genvar gi = 0; gi < N_RD_PORTS; gi++) begin : g_rd
            logic [4:0]       rd_a;
            logic [IDX_W-1:0] rd_idx;
            logic             rd_ok;
            logic             hit;
            logic [XLEN-1:0]  data_d, data_q;
            logic             pend_d, pend_q;

            assign rd_a      = rd_raddr[5*gi +: 5];
            assign rd_idx    = rd_a[IDX_W-1:0];
            assign rd_ok     = run && addr_ok(rd_a);
            assign rd_hi[gi] = rd_a[4];
            // wr_ok already excludes x0, so a match implies a real register.
            assign hit       = (BYPASS != 0) && wr_ok && (wr_addr == rd_a);

            always_comb begin
                data_d = '0;
                pend_d = 1'b0;
                if (rd_ok) begin
                    data_d = hit ? wr_data : regs_q[rd_idx];
                    if (BYPASS != 0) begin
                        pend_d = sb_d[rd_idx];
                    end else begin
                        pend_d = sb_q[rd_idx] ||
                                 (iss_ok && (issue_addr == rd_a));
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    data_q <= '0;
                    pend_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    pend_q <= pend_d;
                end
            end

            assign rd_rdata[XLEN*gi +: XLEN] = data_q;
            assign rd_pending[gi]            = pend_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Address error pulse (RV32E only)
    // -----------------------------------------------------------------------
    logic addr_err_q, addr_err_d;

    assign addr_err_d = run && (RV32E != 0) && ((wr_en && wr_addr[4]) || (|rd_hi));

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;

endmodule
